host_mon: RTL



---
 rtl/host_mon.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/host_mon.sv
// host_mon: snoops S1D13700 8080-style host cycles, classifies them into 18-bit records,
// buffers them in a FIFO and delivers them over wrreq/wrack. Burst compression: HOST_MON_BURST_EN.
module host_mon #(
   parameter int         DW      = 8,
   parameter int         AW      = 11,
   parameter int         FAW     = 4,
   parameter logic [7:0] MWR_CMD = 8'h42,
   parameter logic [7:0] MRD_CMD = 8'h43
) (
   input  logic          clk,
   input  logic          rst_x,
   input  logic          ce_x,
   input  logic          a0,
   input  logic          wr_x,
   input  logic          rd_x,
   input  logic [DW-1:0] dat,
   output logic          wrreq,
   input  logic          wrack,
   output logic [AW-1:0] waddr,
   output logic [17:0]   wdata,
   output logic          ovf
);
   localparam int            DEPTH    = 2**FAW;
   localparam logic [FAW:0]  FULL_CNT = {1'b1, {FAW{1'b0}}};
   localparam logic [3:0]    C_WCMD   = 4'd1;
   localparam logic [3:0]    C_WDAT   = 4'd2;
   localparam logic [3:0]    C_RDAT   = 4'd3;
   localparam logic [3:0]    C_WMEM   = 4'd4;
   localparam logic [3:0]    C_RMEM   = 4'd5;
   // Idle bus: ce_x/wr_x/rd_x high, a0 and data low
   localparam logic [DW+3:0] SYNC_RST = {4'b1011, {DW{1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, HOLD = 2'd2} state_t;

   logic [DW+3:0] sync_p0, sync_p1;
   logic          ce_s, a0_s, wr_s, rd_s;
   logic [DW-1:0] dat_s;
   state_t        state, state_nxt;
   logic [7:0]    cmd;
   logic          ev_vld;
   logic [3:0]    ev_code;
   logic [17:0]   ev_rec;
   logic          push_vld;
   logic [17:0]   push_rec;

   // Stage p0/p1: two-flop synchroniser for the whole host bus
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         sync_p0 <= SYNC_RST;
         sync_p1 <= SYNC_RST;
      end else begin
         sync_p0 <= {ce_x, a0, wr_x, rd_x, dat};
         sync_p1 <= sync_p0;
      end
   end

   assign {ce_s, a0_s, wr_s, rd_s, dat_s} = sync_p1;

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = (!ce_s && (!wr_s || !rd_s)) ? SETUP : IDLE;
         SETUP:   state_nxt = HOLD;
         HOLD:    state_nxt = (ce_s || (wr_s && rd_s)) ? IDLE : HOLD;
         default: state_nxt = IDLE;
      endcase
   end

   // One classification per host cycle, taken in SETUP; a0=0 reads are status reads
   always_comb begin
      ev_vld  = 1'b0;
      ev_code = 4'd0;
      if (state == SETUP) begin
         if (!wr_s) begin
            ev_vld = 1'b1;
            if (a0_s)                ev_code = C_WCMD;
            else if (cmd == MWR_CMD) ev_code = C_WMEM;
            else                     ev_code = C_WDAT;
         end else if (!rd_s && a0_s) begin
            ev_vld  = 1'b1;
            ev_code = (cmd == MRD_CMD) ? C_RMEM : C_RDAT;
         end
      end
   end

   assign ev_rec = {ev_code, 14'(dat_s)};

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x)                           cmd <= 8'd0;
      else if (ev_vld && ev_code == C_WCMD) cmd <= 8'(dat_s);
   end

`ifdef HOST_MON_BURST_EN
   logic        ev_mem, same_burst, close_burst;
   logic        burst_open;
   logic [3:0]  burst_code;
   logic [13:0] burst_cnt;
   logic        pend_vld;
   logic [17:0] pend_rec;

   assign ev_mem      = ev_vld && (ev_code == C_WMEM || ev_code == C_RMEM);
   assign same_burst  = burst_open && ev_mem && (ev_code == burst_code);
   assign close_burst = burst_open && ev_vld && !same_burst;

   // Closing event pushes the burst record now; its own record follows one clock later
   always_comb begin
      push_vld = pend_vld;
      push_rec = pend_rec;
      if (close_burst) begin
         push_vld = 1'b1;
         push_rec = {burst_code, burst_cnt};
      end else if (ev_vld && !ev_mem) begin
         push_vld = 1'b1;
         push_rec = ev_rec;
      end
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         burst_open <= 1'b0;
         burst_code <= 4'd0;
         burst_cnt  <= 14'd0;
         pend_vld   <= 1'b0;
      end else begin
         pend_vld <= close_burst && !ev_mem;
         if (ev_mem) begin
            burst_open <= 1'b1;
            burst_code <= ev_code;
            if (!same_burst)                 burst_cnt <= 14'd1;
            else if (burst_cnt != 14'h3FFF)  burst_cnt <= burst_cnt + 14'd1;
         end else if (close_burst) begin
            burst_open <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (close_burst) pend_rec <= ev_rec;
   end
`else
   assign push_vld = ev_vld;
   assign push_rec = ev_rec;
`endif

   logic [17:0]    mem [DEPTH];
   logic [FAW-1:0] wptr, rptr;
   logic [FAW:0]   cnt;
   logic           full, pop, wr_en;

   assign full  = (cnt == FULL_CNT);
   assign wrreq = (cnt != '0);
   assign pop   = wrreq && wrack;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the push
   assign wr_en = push_vld && (!full || pop);
   assign wdata = wrreq ? mem[rptr] : 18'd0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= push_rec;
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         waddr <= '0;
         ovf   <= 1'b0;
      end else begin
         if (wr_en) wptr <= wptr + FAW'(1);
         if (pop) begin
            rptr  <= rptr + FAW'(1);
            waddr <= waddr + AW'(1);
         end
         if (wr_en && !pop)      cnt <= cnt + (FAW+1)'(1);
         else if (!wr_en && pop) cnt <= cnt - (FAW+1)'(1);
         if (push_vld && full && !pop) ovf <= 1'b1;
      end
   end

endmodule
